klein_sub_nibbles_serial: RTL

//  Nibble-serial SubNibbles layer of the KLEIN round datapath. Accepts a 64-bit state,

---
 rtl/klein_sub_nibbles_serial.sv | 82 ++++++++
 1 files changed

// File: rtl/klein_sub_nibbles_serial.sv
// klein_sub_nibbles_serial: nibble-serial KLEIN SubNibbles layer; define KLEIN_SUBNIB_ADDKEY_EN to fuse AddRoundKey into the load
module sbox (
    input  logic [3:0] x,
    output logic [3:0] y
);
    localparam logic [0:63] sbox_table = 64'h74A91FB0C3268ED5;
    assign y = sbox_table[{x, 2'b00} +: 4];
endmodule

module klein_sub_nibbles_serial #(
    parameter int LANES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:63] in_state,
    input  logic [0:63] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:63] out_state,
    output logic        busy
);
    localparam int W = 4 * LANES;
    localparam logic [3:0] last = 4'(16 / LANES - 1);
    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [0:63] sreg, sreg_n, shifted, load;
    logic [0:W-1] sub;
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("klein_sub_nibbles_serial: illegal LANES=%0d", LANES);
    end
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox u_sbox (.x(sreg[4*g +: 4]), .y(sub[4*g +: 4]));
    end
    if (LANES == 16) begin : g_full
        assign shifted = sub;
    end else begin : g_part
        assign shifted = {sreg[W:63], sub};
    end
`ifdef KLEIN_SUBNIB_ADDKEY_EN
    assign load = in_state ^ in_key;
`else
    logic unused_key;
    assign unused_key = ^in_key;
    assign load = in_state;
`endif
    // next-state, counter and register update plus handshake outputs
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        sreg_n = sreg;
        in_ready = state == IDLE;
        out_valid = state == DONE;
        busy = state != IDLE;
        out_state = state == DONE ? sreg : '0;
        if (state == IDLE && in_valid) begin
            state_n = SUB;
            cnt_n = '0;
            sreg_n = load;
        end else if (state == SUB) begin
            sreg_n = shifted;
            state_n = cnt == last ? DONE : SUB;
            cnt_n = cnt == last ? cnt : cnt + 4'd1;
        end else if (state == DONE && out_ready) begin
            state_n = IDLE;
        end
    end
    // state register; reset aborts any operation in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            sreg <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            sreg <= sreg_n;
        end
    end
endmodule
